// File: rtl/booth_mult4_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier.
package booth_mult4_pkg;

    localparam int unsigned OpW   = 4;
    localparam int unsigned Steps = 4;

    localparam logic [1:0] LastStep = 2'(Steps - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        BoothNop0 = 2'b00,
        BoothAdd  = 2'b01,
        BoothSub  = 2'b10,
        BoothNop1 = 2'b11
    } booth_op_e;

endpackage

// File: rtl/add_sub.sv
// 4-bit two's-complement adder/subtractor with signed overflow flag.
// M=0 computes A+B, M=1 computes A-B.
module add_sub (
    input  logic       M,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] S,
    output logic       Ov
);

    logic [3:0] b_eff;

    always_comb begin
        b_eff = B ^ {4{M}};
        S     = A + b_eff + {3'b000, M};
        // Overflow when both addends share a sign that the sum does not.
        Ov    = (A[3] == b_eff[3]) && (S[3] != A[3]);
    end

endmodule

// File: rtl/booth_mult4.sv
// Sequential radix-2 Booth multiplier: 4x4 signed -> 8-bit signed product,
// one Booth step per clock using a shared add_sub instance.
module booth_mult4
    import booth_mult4_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [7:0] P,
    output logic       busy,
    output logic       done
);

    state_e           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [OpW-1:0]   mreg_q, mreg_d;
    logic [OpW-1:0]   acc_q, acc_d;
    logic [OpW-1:0]   q_q, q_d;
    logic             q1_q, q1_d;
    logic [2*OpW-1:0] p_q, p_d;

    logic             as_m;
    logic [OpW-1:0]   as_s;
    logic             as_ov;
    logic [OpW-1:0]   step_r;
    logic             sign_in;
    booth_op_e        op;

    add_sub u_add_sub (
        .M  (as_m),
        .A  (acc_q),
        .B  (mreg_q),
        .S  (as_s),
        .Ov (as_ov)
    );

    // Booth step result and the sign bit shifted into the accumulator.
    always_comb begin
        op      = booth_op_e'({q_q[0], q1_q});
        as_m    = (op == BoothSub);
        step_r  = acc_q;
        sign_in = acc_q[OpW-1];
        if (op == BoothAdd || op == BoothSub) begin
            step_r  = as_s;
            // True sign of the 5-bit result, so 0-(-8) shifts in a 0.
            sign_in = as_s[OpW-1] ^ as_ov;
        end
    end

    // Datapath next state.
    always_comb begin
        mreg_d = mreg_q;
        acc_d  = acc_q;
        q_d    = q_q;
        q1_d   = q1_q;
        p_d    = p_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mreg_d = A;
                    q_d    = B;
                    acc_d  = '0;
                    q1_d   = 1'b0;
                end
            end
            StRun: begin
                acc_d = {sign_in, step_r[OpW-1:1]};
                q_d   = {step_r[0], q_q[OpW-1:1]};
                q1_d  = q_q[0];
                if (cnt_q == LastStep) begin
                    p_d = {sign_in, step_r, q_q[OpW-1:1]};
                end
            end
            default: ;
        endcase
    end

    // Control next state; busy/done are registered from the next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    cnt_d   = 2'd0;
                end
            end
            StRun: begin
                if (cnt_q == LastStep) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d == StRun);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mreg_q <= '0;
            acc_q  <= '0;
            q_q    <= '0;
            q1_q   <= 1'b0;
            p_q    <= '0;
        end else begin
            mreg_q <= mreg_d;
            acc_q  <= acc_d;
            q_q    <= q_d;
            q1_q   <= q1_d;
            p_q    <= p_d;
        end
    end

    assign P    = p_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_booth_mult4.sv
// Self-checking bench for booth_mult4: directed vector table, corner sequences,
// random operands and a full operand sweep against a signed-product model.
module tb_booth_mult4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic [7:0] P;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;
    logic [7:0] p_last;

    booth_mult4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .P     (P),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } vec_t;

    function automatic logic [7:0] ref_prod(input logic [3:0] a, input logic [3:0] b);
        int prod;
        prod = $signed(a) * $signed(b);
        return prod[7:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one multiply from IDLE and check the full handshake; ends in IDLE.
    task automatic run_mult(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp,
                            input string name);
        int bad;
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = 4'($urandom);
        B = 4'($urandom);
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            if (busy !== 1'b1 || done !== 1'b0 || P !== p_last) bad++;
        end
        check({name, " run"}, bad, 0);
        @(negedge clk);
        check({name, " done"}, {busy, done}, 2'b01);
        check({name, " P"}, P, exp);
        @(negedge clk);
        check({name, " idle"}, {busy, done, P}, {2'b00, exp});
        p_last = exp;
    endtask

    initial begin
        vec_t vecs[$];
        int   dcnt;
        int   bad;

        rst_n = 1'b0;
        start = 1'b0;
        A = 4'h0;
        B = 4'h0;
        p_last = 8'h00;
        #1;
        check("reset outputs", {busy, done, P}, 10'h000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        vecs.push_back('{a: 4'h3, b: 4'h2, p: 8'h06});
        vecs.push_back('{a: 4'h8, b: 4'h8, p: 8'h40});
        vecs.push_back('{a: 4'h7, b: 4'h8, p: 8'hC8});
        vecs.push_back('{a: 4'hF, b: 4'hF, p: 8'h01});
        vecs.push_back('{a: 4'h7, b: 4'h7, p: 8'h31});
        vecs.push_back('{a: 4'h8, b: 4'h7, p: 8'hC8});
        vecs.push_back('{a: 4'h8, b: 4'h1, p: 8'hF8});
        vecs.push_back('{a: 4'h0, b: 4'h8, p: 8'h00});
        vecs.push_back('{a: 4'h5, b: 4'hD, p: 8'hF1});
        foreach (vecs[i]) run_mult(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));

        // start pulses during RUN and DONE must be ignored.
        @(negedge clk);
        A = 4'h2; B = 4'h3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; A = 4'h7; B = 4'h7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("ignore done", {busy, done, P}, {2'b01, 8'h06});
        start = 1'b1; A = 4'h1; B = 4'h1;
        @(negedge clk);
        start = 1'b0;
        dcnt = 0;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            if (done === 1'b1) dcnt++;
            if (busy !== 1'b0 || P !== 8'h06) bad++;
            @(negedge clk);
        end
        check("ignore extra done", dcnt, 0);
        check("ignore stays idle", bad, 0);
        p_last = 8'h06;

        // Reset in the middle of a multiply.
        A = 4'h5; B = 4'h3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset outputs", {busy, done, P}, 10'h000);
        @(negedge clk);
        rst_n = 1'b1;
        p_last = 8'h00;
        run_mult(4'h5, 4'h3, 8'h0F, "after reset");

        for (int i = 0; i < 30; i++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            ra = 4'($urandom);
            rb = 4'($urandom);
            run_mult(ra, rb, ref_prod(ra, rb), $sformatf("rand %0h*%0h", ra, rb));
        end

        // Sweep with start held high: one result every 6 cycles.
        start = 1'b1;
        for (int i = 0; i < 256; i++) begin
            logic [3:0] sa;
            logic [3:0] sb;
            logic [7:0] exp;
            sa = 4'(i >> 4);
            sb = 4'(i);
            exp = ref_prod(sa, sb);
            A = sa;
            B = sb;
            bad = 0;
            for (int k = 1; k <= 6; k++) begin
                @(negedge clk);
                if (k == 5) begin
                    if (done !== 1'b1 || P !== exp) bad++;
                end else if (done !== 1'b0) begin
                    bad++;
                end
            end
            check($sformatf("sweep %0h*%0h", sa, sb), bad, 0);
        end
        start = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog keeps the run bounded.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
